// File: rtl/dino_pkg.sv
// dino_pkg: shared sprite geometry, spawn layout, colours and run-state encoding for the sprite compositor.
package dino_pkg;
  localparam int PL_W      = 60;
  localparam int PL_H      = 60;
  localparam int OB_W      = 49;
  localparam int OB_H      = 80;
  localparam int SCR_W     = 640;
  localparam int GROUND    = 335;
  localparam int OB_Y      = GROUND - OB_H;
  localparam int SPAWN_X   = 640;
  localparam int SPAWN_GAP = 200;
  localparam logic [11:0] FG_COLOR = 12'h000;
  localparam logic [11:0] BG_COLOR = 12'hFFF;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t CRASH = 2'd2;
  function automatic logic [10:0] spawn_x(input int i);
    return 11'(SPAWN_X + i * SPAWN_GAP);
  endfunction
endpackage

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: per-channel obstacle x positions with respawn, per-frame scroll and wrap back to the spawn column.
module obstacle_scroller
  import dino_pkg::*;
#(
  parameter int NUM_OBST = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   respawn_i,
  input  logic                   step_i,
  input  logic [3:0]             speed_i,
  output logic [NUM_OBST*11-1:0] ox_o
);
  for (genvar i = 0; i < NUM_OBST; i++) begin : g_ch
    logic [10:0] x_q, x_d;
    always_comb x_d = respawn_i ? spawn_x(i) :
                      !step_i ? x_q :
                      (x_q <= 11'(speed_i)) ? 11'(SPAWN_X) : x_q - 11'(speed_i);
    always_ff @(posedge clk or posedge reset)
      if (reset) x_q <= spawn_x(i);
      else x_q <= x_d;
    assign ox_o[11*i+:11] = x_q;
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage pixel pipeline compositing player, obstacles and background, plus run/crash FSM and score.
module sprite_compositor
  import dino_pkg::*;
#(
  parameter int NUM_OBST = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_en_i,
  input  logic                   frame_end_i,
  input  logic                   active_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  input  logic [9:0]             x_i,
  input  logic [8:0]             y_i,
  input  logic [9:0]             pl_x_i,
  input  logic [8:0]             pl_y_i,
  input  logic [3:0]             speed_i,
  input  logic                   start_i,
  output logic [11:0]            pl_addr_o,
  input  logic                   pl_bit_i,
  output logic [NUM_OBST*13-1:0] ob_addr_o,
  input  logic [NUM_OBST-1:0]    ob_bit_i,
  output logic [18:0]            bg_addr_o,
  input  logic                   bg_bit_i,
  output logic [11:0]            rgb_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   collision_o,
  output logic [15:0]            score_o
);
  state_t state_q, state_d;
  logic [15:0] score_q, score_d;
  logic hit_q, hit_d;
  logic [NUM_OBST*11-1:0] ox;
  logic run, respawn, step;
  logic pl_in;
  logic [NUM_OBST-1:0] ob_in;
  logic [11:0] pl_addr_d;
  logic [NUM_OBST*13-1:0] ob_addr_d;
  logic [18:0] bg_addr_d;
  logic act1_q, hs1_q, vs1_q, pl_in1_q;
  logic [NUM_OBST-1:0] ob_in1_q;
  logic [11:0] pl_addr_q;
  logic [NUM_OBST*13-1:0] ob_addr_q;
  logic [18:0] bg_addr_q;
  logic [11:0] rgb_q, rgb_d;
  logic hs2_q, vs2_q;
  logic pl_op, ob_op, hit;
  always_comb begin
    pl_in = x_i >= pl_x_i && {1'b0, x_i} < {1'b0, pl_x_i} + 11'(PL_W) &&
            y_i >= pl_y_i && {1'b0, y_i} < {1'b0, pl_y_i} + 10'(PL_H);
    pl_addr_d = pl_in ? 12'((y_i - pl_y_i) * PL_W + (x_i - pl_x_i)) : '0;
    bg_addr_d = 19'(x_i + SCR_W * y_i);
  end
  for (genvar i = 0; i < NUM_OBST; i++) begin : g_ob
    assign ob_in[i] = {1'b0, x_i} >= ox[11*i+:11] && {1'b0, x_i} < ox[11*i+:11] + 11'(OB_W) &&
                      y_i >= 9'(OB_Y) && y_i < 9'(OB_Y + OB_H);
    assign ob_addr_d[13*i+:13] = ob_in[i] ?
      13'((y_i - 9'(OB_Y)) * OB_W + ({1'b0, x_i} - ox[11*i+:11])) : '0;
  end
  // ROM bits arriving now belong to the pixel held in S1.
  always_comb begin
    pl_op = pl_in1_q & pl_bit_i;
    ob_op = |(ob_in1_q & ob_bit_i);
    hit   = act1_q & pl_op & ob_op;
    rgb_d = !act1_q ? 12'h000 : (pl_op | ob_op | bg_bit_i) ? FG_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      act1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      pl_in1_q  <= 1'b0;
      ob_in1_q  <= '0;
      pl_addr_q <= '0;
      ob_addr_q <= '0;
      bg_addr_q <= '0;
      rgb_q     <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
    end else if (pix_en_i) begin
      act1_q    <= active_i;
      hs1_q     <= hsync_i;
      vs1_q     <= vsync_i;
      pl_in1_q  <= pl_in;
      ob_in1_q  <= ob_in;
      pl_addr_q <= pl_addr_d;
      ob_addr_q <= ob_addr_d;
      bg_addr_q <= bg_addr_d;
      rgb_q     <= rgb_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  // A hit seen in the frame_end cycle is carried into the next frame.
  always_comb begin
    run     = state_q == RUN;
    respawn = start_i & !run;
    step    = run & frame_end_i & !hit_q;
    hit_d   = frame_end_i ? (pix_en_i & hit) : (hit_q | (pix_en_i & hit));
    state_d = respawn ? RUN : (run & frame_end_i & hit_q) ? CRASH : state_q;
    score_d = respawn ? 16'h0000 : (step && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  obstacle_scroller #(.NUM_OBST(NUM_OBST)) u_scroll (
    .clk      (clk),
    .reset    (reset),
    .respawn_i(respawn),
    .step_i   (step),
    .speed_i  (speed_i),
    .ox_o     (ox)
  );
  assign pl_addr_o   = pl_addr_q;
  assign ob_addr_o   = ob_addr_q;
  assign bg_addr_o   = bg_addr_q;
  assign rgb_o       = rgb_q;
  assign hsync_o     = hs2_q;
  assign vsync_o     = vs2_q;
  assign collision_o = state_q == CRASH;
  assign score_o     = score_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vectors with a queue scoreboard on the pixel output plus direct state checks.
module tb_sprite_compositor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0, frame_end = 1'b0, active = 1'b0, hs = 1'b0, vs = 1'b0, start = 1'b0;
  logic [9:0] x = '0, pl_x = 10'd100;
  logic [8:0] y = '0, pl_y = 9'd200;
  logic [3:0] speed = '0;
  logic pl_bit = 1'b0, bg_bit = 1'b0;
  logic [2:0] ob_bit = '0;
  logic pl_fill = 1'b0, ob_fill = 1'b0, bg_fill = 1'b0;
  logic [11:0] pl_addr, rgb;
  logic [38:0] ob_addr;
  logic [18:0] bg_addr;
  logic hsync, vsync, collision;
  logic [15:0] score;
  int checks = 0, errors = 0;
  logic [13:0] expq[$];
  bit tag_now = 0, cur_t = 0, prev_t = 0;
  int em[3];
  int esc;

  sprite_compositor #(.NUM_OBST(3)) dut (
    .clk(clk), .reset(reset), .pix_en_i(pix_en), .frame_end_i(frame_end), .active_i(active),
    .hsync_i(hs), .vsync_i(vs), .x_i(x), .y_i(y), .pl_x_i(pl_x), .pl_y_i(pl_y), .speed_i(speed),
    .start_i(start), .pl_addr_o(pl_addr), .pl_bit_i(pl_bit), .ob_addr_o(ob_addr), .ob_bit_i(ob_bit),
    .bg_addr_o(bg_addr), .bg_bit_i(bg_bit), .rgb_o(rgb), .hsync_o(hsync), .vsync_o(vsync),
    .collision_o(collision), .score_o(score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pl_bit <= pl_fill;
    ob_bit <= {3{ob_fill}};
    bg_bit <= bg_fill;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (pix_en) begin
        prev_t = cur_t;
        cur_t = tag_now;
        if (prev_t) begin
          #1;
          if (expq.size() == 0) chk("pixel_unexpected", 1, 0);
          else chk("pixel", {18'd0, hsync, vsync, rgb}, {18'd0, expq.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic pix(input int px, input int py, input bit act, input bit h, input bit v,
                     input bit fe, input bit tg, input logic [13:0] e);
    @(negedge clk);
    x = 10'(px); y = 9'(py); active = act; hs = h; vs = v; frame_end = fe; pix_en = 1'b1; tag_now = tg;
    if (tg) expq.push_back(e);
    @(negedge clk);
    pix_en = 1'b0; frame_end = 1'b0; tag_now = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      pix(0, 0, 0, 0, 0, 1, 0, '0);
      for (int i = 0; i < 3; i++) em[i] = (em[i] <= int'(speed)) ? 640 : em[i] - int'(speed);
      esc++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_ox(input string name);
    for (int i = 0; i < 3; i++) chk(name, 32'(dut.ox[11*i+:11]), 32'(em[i]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ox0", 32'(dut.ox[10:0]), 640);
    chk("reset_ox1", 32'(dut.ox[21:11]), 840);
    chk("reset_ox2", 32'(dut.ox[32:22]), 1040);
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_hsync", 32'(hsync), 0);
    chk("reset_collision", 32'(collision), 0);
    chk("reset_score", 32'(score), 0);
    chk("reset_state", 32'(dut.state_q), 0);
    pulse_start();
    chk("start_state", 32'(dut.state_q), 1);
    em = '{640, 840, 1040};
    esc = 0;
    speed = 4'd4;
    frames(10);
    chk("scroll10_ox0", 32'(dut.ox[10:0]), 600);
    chk("scroll10_score", 32'(score), 10);
    chk_ox("scroll10_model");
    speed = 4'd13;
    frames(45);
    speed = 4'd12;
    frames(1);
    chk("near_wrap_ox0", 32'(dut.ox[10:0]), 3);
    speed = 4'd4;
    frames(1);
    chk("wrap_ox0", 32'(dut.ox[10:0]), 640);
    chk_ox("wrap_model");
    chk("wrap_score", 32'(score), 57);
    speed = 4'd0;
    pl_fill = 1'b1;
    ob_fill = 1'b0;
    bg_fill = 1'b0;
    pix(10, 10, 1, 1, 0, 0, 1, {2'b10, 12'hFFF});
    chk("bg_addr", 32'(bg_addr), 6410);
    chk("pl_addr_out", 32'(pl_addr), 0);
    pix(105, 202, 1, 0, 1, 0, 1, {2'b01, 12'h000});
    chk("pl_addr_in", 32'(pl_addr), 125);
    pix(105, 202, 0, 1, 1, 0, 1, {2'b11, 12'h000});
    bg_fill = 1'b1;
    pix(10, 10, 1, 0, 0, 0, 1, {2'b00, 12'h000});
    pix(0, 0, 0, 0, 0, 0, 0, '0);
    bg_fill = 1'b0;
    speed = 4'd10;
    frames(10);
    chk("scroll_ox0_540", 32'(dut.ox[10:0]), 540);
    chk_ox("scroll_model");
    speed = 4'd0;
    pl_x = 10'd530;
    pl_y = 9'd250;
    ob_fill = 1'b1;
    pix(545, 260, 1, 0, 0, 0, 1, {2'b00, 12'h000});
    chk("ob0_addr", 32'(ob_addr[12:0]), 250);
    chk("pl_addr_overlap", 32'(pl_addr), 615);
    pix(0, 0, 0, 0, 0, 0, 0, '0);
    chk("no_crash_midframe", 32'(collision), 0);
    pix(0, 0, 0, 0, 0, 1, 0, '0);
    chk("crash_collision", 32'(collision), 1);
    chk("crash_state", 32'(dut.state_q), 2);
    chk("crash_score", 32'(score), 67);
    speed = 4'd4;
    for (int k = 0; k < 3; k++) pix(0, 0, 0, 0, 0, 1, 0, '0);
    chk("crash_freeze_ox0", 32'(dut.ox[10:0]), 540);
    chk("crash_freeze_score", 32'(score), 67);
    chk("crash_hold", 32'(collision), 1);
    pulse_start();
    chk("restart_collision", 32'(collision), 0);
    chk("restart_state", 32'(dut.state_q), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_ox0", 32'(dut.ox[10:0]), 640);
    chk("restart_ox2", 32'(dut.ox[32:22]), 1040);
    em = '{640, 840, 1040};
    esc = 0;
    frames(1);
    pulse_start();
    chk("start_in_run_ox0", 32'(dut.ox[10:0]), 636);
    chk("start_in_run_score", 32'(score), 1);
    speed = 4'd0;
    pl_x = 10'd640;
    pl_y = 9'd250;
    pix(650, 260, 0, 0, 0, 0, 1, {2'b00, 12'h000});
    pix(0, 0, 0, 0, 0, 0, 0, '0);
    frames(5);
    chk("inactive_no_crash", 32'(collision), 0);
    chk("freeze_ox0", 32'(dut.ox[10:0]), 636);
    chk("freeze_score", 32'(score), 6);
    chk_ox("freeze_model");
    speed = 4'd4;
    frames(2);
    chk("pre_reset_score", 32'(score), 8);
    pix(10, 10, 1, 1, 1, 0, 0, '0);
    pix(11, 10, 1, 1, 1, 0, 0, '0);
    chk("pre_reset_hsync", 32'(hsync), 1);
    chk("pre_reset_rgb", 32'(rgb), 32'hFFF);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_rgb", 32'(rgb), 0);
    chk("areset_hsync", 32'(hsync), 0);
    chk("areset_vsync", 32'(vsync), 0);
    chk("areset_score", 32'(score), 0);
    chk("areset_collision", 32'(collision), 0);
    chk("areset_bg_addr", 32'(bg_addr), 0);
    chk("areset_state", 32'(dut.state_q), 0);
    chk("areset_ox0", 32'(dut.ox[10:0]), 640);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
